// File: rtl/msrv_32_fetch_ctrl.sv
// msrv_32_fetch_ctrl: PC owner and imem request sequencer with redirect, kill, stall and fault handling
module msrv_32_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          MAX_WAIT  = 16
) (
  input  logic        ms_risc32_mp_clk_in,
  input  logic        ms_risc32_mp_rst_in,
  input  logic        stall_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_vector_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        fault_out
);
  typedef enum logic [1:0] {BOOT, FETCH, KILL, FAULT} state_t;
  state_t      state, state_n;
  logic [31:0] pend_pc, pend_n, addr_n, instr_n, ipc_n, tgt;
  logic [7:0]  wait_cnt, wait_n;
  logic        valid_n, ack, redir, bad;
  assign imem_req_out = (state == FETCH || state == KILL) && !(state == FETCH && instr_valid_out && stall_in);
  assign ack          = imem_req_out && imem_ack_in;
  assign redir        = trap_taken_in || mret_in || branch_taken_in;
  assign tgt          = trap_taken_in ? trap_vector_in : mret_in ? epc_in : branch_target_in;
  assign bad          = (redir && tgt[1:0] != 2'b00) || (imem_req_out && !ack && wait_cnt == 8'(MAX_WAIT - 1));
  assign wait_n       = (imem_req_out && !ack) ? wait_cnt + 8'd1 : 8'd0;
  assign fault_out    = state == FAULT;
  // next-state: redirect arbitration, kill of in-flight fetch, sequential PC advance
  always_comb begin
    state_n = state;
    addr_n  = imem_addr_out;
    pend_n  = pend_pc;
    valid_n = instr_valid_out;
    instr_n = instr_out;
    ipc_n   = instr_pc_out;
    case (state)
      BOOT: state_n = FETCH;
      FETCH: begin
        if (bad) begin
          state_n = FAULT;
          valid_n = 1'b0;
        end else if (redir) begin
          valid_n = 1'b0;
          state_n = (imem_req_out && !ack) ? KILL : FETCH;
          pend_n  = (imem_req_out && !ack) ? tgt : pend_pc;
          addr_n  = (imem_req_out && !ack) ? imem_addr_out : tgt;
        end else if (ack) begin
          instr_n = imem_data_in;
          ipc_n   = imem_addr_out;
          valid_n = 1'b1;
          addr_n  = imem_addr_out + 32'd4;
        end else if (instr_valid_out && !stall_in) begin
          valid_n = 1'b0;
        end
      end
      KILL: begin
        if (bad) begin
          state_n = FAULT;
        end else begin
          pend_n  = redir ? tgt : pend_pc;
          addr_n  = ack ? (redir ? tgt : pend_pc) : imem_addr_out;
          state_n = ack ? FETCH : KILL;
        end
      end
      default: state_n = FAULT;
    endcase
  end
  // state and datapath registers, asynchronously reset
  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      state           <= BOOT;
      imem_addr_out   <= BOOT_ADDR;
      pend_pc         <= 32'd0;
      instr_valid_out <= 1'b0;
      instr_out       <= 32'd0;
      instr_pc_out    <= 32'd0;
      wait_cnt        <= 8'd0;
    end else begin
      state           <= state_n;
      imem_addr_out   <= addr_n;
      pend_pc         <= pend_n;
      instr_valid_out <= valid_n;
      instr_out       <= instr_n;
      instr_pc_out    <= ipc_n;
      wait_cnt        <= wait_n;
    end
  end
endmodule

// File: tb/tb_msrv_32_fetch_ctrl.sv
// tb_msrv_32_fetch_ctrl: directed scenarios plus random stimulus against a behavioural fetch model
module tb_msrv_32_fetch_ctrl;
  localparam int          MAX_WAIT = 16;
  localparam logic [31:0] BOOT     = 32'h0000_0000;
  logic        clk = 1'b0, rst = 1'b1;
  logic        stall = 1'b0, trap = 1'b0, mret = 1'b0, br = 1'b0, ack = 1'b0;
  logic [31:0] tv = 32'd0, epc = 32'd0, bt = 32'd0, data = 32'd0;
  logic        req, valid, fault;
  logic [31:0] addr, instr, ipc;
  int          n_chk = 0, n_err = 0, cnt;
  logic        m_boot, m_dead, m_kill, m_valid;
  logic [31:0] m_pc, m_pend, m_instr, m_ipc;
  int          m_wait;

  always #5 clk = ~clk;

  msrv_32_fetch_ctrl #(.BOOT_ADDR(BOOT), .MAX_WAIT(MAX_WAIT)) dut (
    .ms_risc32_mp_clk_in(clk), .ms_risc32_mp_rst_in(rst), .stall_in(stall),
    .trap_taken_in(trap), .trap_vector_in(tv), .mret_in(mret), .epc_in(epc),
    .branch_taken_in(br), .branch_target_in(bt), .imem_req_out(req),
    .imem_addr_out(addr), .imem_ack_in(ack), .imem_data_in(data),
    .instr_valid_out(valid), .instr_out(instr), .instr_pc_out(ipc), .fault_out(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_dead = 0; m_kill = 0; m_valid = 0;
    m_pc = BOOT; m_pend = 0; m_instr = 0; m_ipc = 0; m_wait = 0;
  endtask

  // compare outputs against the model, advance the model by one clock, then clock the DUT
  task automatic step();
    logic        m_req, a, red, bad;
    logic [31:0] t;
    #1;
    m_req = !m_boot && !m_dead && (m_kill || !(m_valid && stall));
    check("req", {31'd0, req}, {31'd0, m_req});
    check("addr", addr, m_pc);
    check("valid", {31'd0, valid}, {31'd0, m_valid});
    check("instr", instr, m_instr);
    check("instr_pc", ipc, m_ipc);
    check("fault", {31'd0, fault}, {31'd0, m_dead});
    a   = m_req && ack;
    red = trap || mret || br;
    t   = trap ? tv : (mret ? epc : bt);
    bad = (red && t % 4 != 0) || (m_req && !a && m_wait == MAX_WAIT - 1);
    if (m_boot) m_boot = 0;
    else if (!m_dead) begin
      if (bad) begin
        m_dead = 1; m_valid = 0;
      end else if (m_kill) begin
        if (red) m_pend = t;
        if (a) begin m_pc = m_pend; m_kill = 0; end
      end else if (red) begin
        m_valid = 0;
        if (m_req && !a) begin m_pend = t; m_kill = 1; end
        else m_pc = t;
      end else if (a) begin
        m_instr = data; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end else if (m_valid && !stall) m_valid = 0;
    end
    m_wait = (m_req && !a) ? m_wait + 1 : 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; #1;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", addr, BOOT);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", ipc, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic idle();
    stall = 0; trap = 0; mret = 0; br = 0;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    int r;
    t = $urandom;
    r = $urandom_range(0, 99);
    return r < 3 ? (t | 32'd1) : (r < 10 ? 32'hFFFF_FFFC : (t & ~32'd3));
  endfunction

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset(); idle(); ack = 1; data = 32'h1111_0000;
    step();
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", addr, 32'(i * 4));
      data = 32'h1111_0000 + 32'(i);
      step();
    end
    check("seq_pc_trail", ipc, 32'hC);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req", {31'd0, req}, 32'd0);
      check("stall_instr", instr, 32'h1111_0003);
    end
    stall = 0; step(); step();
    check("post_stall_pc", ipc, 32'h14);
    do_reset(); idle(); ack = 0; data = 32'hDEAD_BEEF;
    step();
    br = 1; bt = 32'h200; step();
    br = 0; step(); step();
    ack = 1; step();
    check("kill_addr", addr, 32'h200);
    check("kill_valid", {31'd0, valid}, 32'd0);
    trap = 1; tv = 32'h100; mret = 1; epc = 32'h80; br = 1; bt = 32'h40;
    step(); idle();
    check("prio_addr", addr, 32'h100);
    br = 1; bt = 32'h202; step(); idle();
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_req", {31'd0, req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      br = 1; bt = 32'h400; step();
    end
    idle();
    check("fault_sticky", {31'd0, fault}, 32'd1);
    do_reset(); idle(); ack = 0;
    step();
    cnt = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      if (req) cnt++;
      step();
    end
    check("timeout_cycles", 32'(cnt), 32'd16);
    do_reset(); idle(); ack = 1; data = 32'h5555_AAAA;
    step();
    br = 1; bt = 32'hFFFF_FFFC; step(); br = 0;
    check("wrap_tgt", addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", addr, 32'h0);
    check("wrap_pc", ipc, 32'hFFFF_FFFC);
    for (int i = 0; i < 3000; i++) begin
      if ((m_dead && $urandom_range(0, 7) == 0) || $urandom_range(0, 399) == 0) do_reset();
      stall = $urandom_range(0, 9) < 3;
      ack   = $urandom_range(0, 9) < 6;
      data  = $urandom;
      trap  = $urandom_range(0, 39) == 0;
      mret  = $urandom_range(0, 29) == 0;
      br    = $urandom_range(0, 14) == 0;
      tv    = rand_tgt();
      epc   = rand_tgt();
      bt    = rand_tgt();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
